// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
//   Shared definitions for the RV32M multiply/divide unit:
//   - funct3 operation encodings
//   - FSM state encoding
//   - per-class decode masks (bit N set = funct3 value N belongs to the class),
//     shared by the datapath decoder and any hazard logic that needs them
//   - in_class(): mask lookup helper
package muldiv_unit_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // High-half multiplies: MULH, MULHSU, MULHU
    localparam logic [7:0] MASK_MULH_CLASS = 8'b0000_1110;
    // Everything that runs through the divider: DIV, DIVU, REM, REMU
    localparam logic [7:0] MASK_DIV_CLASS  = 8'b1111_0000;
    // Remainder results: REM, REMU
    localparam logic [7:0] MASK_REM_CLASS  = 8'b1100_0000;
    // Signed divide/remainder: DIV, REM
    localparam logic [7:0] MASK_SDIV_CLASS = 8'b0101_0000;
    // Operand a treated as signed: MULH, MULHSU, DIV, REM
    localparam logic [7:0] MASK_A_SIGNED   = 8'b0101_0110;
    // Operand b treated as signed: MULH, DIV, REM
    localparam logic [7:0] MASK_B_SIGNED   = 8'b0101_0010;

    function automatic logic in_class(input logic [2:0] op, input logic [7:0] mask);
        return mask[op];
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative RV32M multiply/divide unit. Radix-2 shift-add multiplier and
//   restoring divider working on operand magnitudes, followed by a sign-fix
//   cycle. Divide-by-zero and signed overflow complete on a one-cycle fast path.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   flush             abort any operation in flight (next state IDLE)
//   in_valid/in_ready request handshake; in_ready high only in IDLE
//   op, a, b, tag_in  funct3, operands rs1/rs2, opaque tag captured on accept
//   out_valid/out_ready result handshake; result/tag_out held while stalled
//   result, tag_out   operation result and its tag
//   zero              result == 0
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] tag_out,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [2:0]       op_q;
    logic             neg_res;      // product / quotient must be negated
    logic             neg_rem;      // remainder must be negated (sign of a)
    logic [WIDTH-1:0] hi;           // product high half / partial remainder
    logic [WIDTH-1:0] lo;           // multiplier bits / dividend -> quotient
    logic [WIDTH-1:0] mcand;        // multiplicand or divisor magnitude
    logic [CNT_W-1:0] cnt;

    // Two's-complement conditional negate; with n = sign it is also abs().
    function automatic logic [2*WIDTH-1:0] cond_neg(input logic [2*WIDTH-1:0] v,
                                                    input logic n);
        return n ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    logic               a_neg, b_neg;
    logic [2*WIDTH-1:0] a_ext, b_ext;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               div_zero, div_ovf, fast_hit;
    logic [WIDTH-1:0]   fast_res;
    logic               div_mode;
    logic [WIDTH:0]     add_a, add_b, add_sum;
    logic [2*WIDTH-1:0] prod_fix, quo_ext, rem_ext;
    logic [WIDTH-1:0]   fix_res;
    logic               unused_bits;

    always_comb begin
        // Request decode: operand signs and magnitudes
        a_neg = in_class(op, MASK_A_SIGNED) & a[WIDTH-1];
        b_neg = in_class(op, MASK_B_SIGNED) & b[WIDTH-1];
        a_ext = cond_neg({{WIDTH{1'b0}}, a}, a_neg);
        b_ext = cond_neg({{WIDTH{1'b0}}, b}, b_neg);
        a_mag = a_ext[WIDTH-1:0];
        b_mag = b_ext[WIDTH-1:0];

        div_zero = in_class(op, MASK_DIV_CLASS) && (b == '0);
        div_ovf  = in_class(op, MASK_SDIV_CLASS) && (a == MOST_NEG) && (b == '1);
        fast_hit = div_zero | div_ovf;
        if (div_zero)
            fast_res = in_class(op, MASK_REM_CLASS) ? a : '1;
        else
            fast_res = in_class(op, MASK_REM_CLASS) ? '0 : a;

        // Shared WIDTH+1-bit adder: add multiplicand, or trial-subtract divisor
        // from the partial remainder shifted left by one dividend bit.
        div_mode = in_class(op_q, MASK_DIV_CLASS);
        add_a    = div_mode ? {hi, lo[WIDTH-1]} : {1'b0, hi};
        add_b    = {1'b0, mcand};
        add_sum  = div_mode ? (add_a - add_b) : (add_a + add_b);

        // Sign fix and result select
        prod_fix = cond_neg({hi, lo}, neg_res);
        quo_ext  = cond_neg({{WIDTH{1'b0}}, lo}, neg_res);
        rem_ext  = cond_neg({{WIDTH{1'b0}}, hi}, neg_rem);
        if (div_mode)
            fix_res = in_class(op_q, MASK_REM_CLASS) ? rem_ext[WIDTH-1:0]
                                                     : quo_ext[WIDTH-1:0];
        else if (in_class(op_q, MASK_MULH_CLASS))
            fix_res = prod_fix[2*WIDTH-1:WIDTH];
        else
            fix_res = prod_fix[WIDTH-1:0];

        unused_bits = ^{a_ext[2*WIDTH-1:WIDTH], b_ext[2*WIDTH-1:WIDTH],
                        quo_ext[2*WIDTH-1:WIDTH], rem_ext[2*WIDTH-1:WIDTH]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            result  <= '0;
            tag_out <= '0;
            cnt     <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q    <= op;
                        tag_out <= tag_in;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        cnt     <= '0;
                        if (fast_hit) begin
                            result <= fast_res;
                            state  <= DONE;
                        end else begin
                            hi    <= '0;
                            state <= CALC;
                            if (in_class(op, MASK_DIV_CLASS)) begin
                                lo    <= a_mag;
                                mcand <= b_mag;
                            end else begin
                                lo    <= b_mag;
                                mcand <= a_mag;
                            end
                        end
                    end
                end
                CALC: begin
                    if (div_mode) begin
                        // Restoring step: keep the difference when it did not borrow
                        if (!add_sum[WIDTH]) begin
                            hi <= add_sum[WIDTH-1:0];
                            lo <= {lo[WIDTH-2:0], 1'b1};
                        end else begin
                            hi <= {hi[WIDTH-2:0], lo[WIDTH-1]};
                            lo <= {lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        // Shift-add step: {carry, hi, lo} >> 1 after optional add
                        if (lo[0]) begin
                            hi <= add_sum[WIDTH:1];
                            lo <= {add_sum[0], lo[WIDTH-1:1]};
                        end else begin
                            hi <= {1'b0, hi[WIDTH-1:1]};
                            lo <= {hi[0], lo[WIDTH-1:1]};
                        end
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER)
                        state <= FIX;
                end
                FIX: begin
                    result <= fix_res;
                    state  <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign zero      = (result == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Directed and randomized bench for muldiv_unit (WIDTH=32, TAG_W=5).
//   Expected results come from a 64-bit arithmetic model of the RV32M rules.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready, zero;
    logic [2:0]  op;
    logic [31:0] a, b, result;
    logic [4:0]  tag_in, tag_out;

    int n_checks = 0;
    int n_err    = 0;

    muldiv_unit #(.WIDTH(32), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .tag_out(tag_out), .zero(zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        logic signed [63:0] sx, sy, ux, uy, p;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'b0, x};
        uy = {32'b0, y};
        p  = '0;
        case (o)
            3'd0: begin p = sx * sy; return p[31:0];  end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin if (y == 0) return 32'hFFFF_FFFF; p = sx / sy; return p[31:0]; end
            3'd5: begin if (y == 0) return 32'hFFFF_FFFF; p = ux / uy; return p[31:0]; end
            3'd6: begin if (y == 0) return x; p = sx % sy; return p[31:0]; end
            default: begin if (y == 0) return x; p = ux % uy; return p[31:0]; end
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] o, input logic [31:0] x,
                                   input logic [31:0] y);
        return o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, exp);
        end
    endtask

    // Issue one op, wait for its result, check it, complete the handshake.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] t, output logic [31:0] got);
        logic [31:0] exp_r;
        int          exp_lat;
        int          k;
        exp_r   = model(o, x, y);
        exp_lat = is_fast(o, x, y) ? 1 : 34;
        @(negedge clk);
        check("in_ready_idle", {31'b0, in_ready}, 32'd1);
        op = o; a = x; b = y; tag_in = t; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; tag_in = 5'($urandom);
        @(negedge clk);
        k = 1;
        if (exp_lat > 1) check("in_ready_busy", {31'b0, in_ready}, 32'd0);
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), 32'(exp_lat));
        check("result", result, exp_r);
        check("tag_out", {27'b0, tag_out}, {27'b0, t});
        check("zero", {31'b0, zero}, {31'b0, exp_r == 0});
        got = result;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("out_valid_after_hs", {31'b0, out_valid}, 32'd0);
        check("in_ready_after_hs", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] got, x, y, exp_r;
        logic [2:0]  o;
        int          k;
        bit          seen;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0; tag_in = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_tag_out", {27'b0, tag_out}, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd1);

        // Directed cases
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, got);        check("mul_7_m3", got, 32'hFFFF_FFEB);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, got); check("mulh_min", got, 32'h4000_0000);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, got); check("mulhu_max", got, 32'hFFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, got); check("mulhsu_max", got, 32'hFFFF_FFFF);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, got);         check("div_m7_2", got, 32'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, got);         check("rem_m7_2", got, 32'hFFFF_FFFF);
        run_op(3'd5, 32'hFFFF_FFFE, 32'd2, 5'd6, got);         check("divu_big", got, 32'h7FFF_FFFF);
        run_op(3'd6, 32'd6, 32'd3, 5'd7, got);                 check("rem_6_3", got, 32'd0);
        run_op(3'd4, 32'd5, 32'd0, 5'd8, got);                 check("div_by0", got, 32'hFFFF_FFFF);
        run_op(3'd7, 32'd5, 32'd0, 5'd10, got);                check("remu_by0", got, 32'd5);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, got); check("div_ovf", got, 32'h8000_0000);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, got); check("rem_ovf", got, 32'd0);

        // Randomized ops, biased toward the special operand classes
        for (int i = 0; i < 30; i++) begin
            o = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: begin x = $urandom; y = 32'd0; end
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: begin x = 32'($urandom_range(0, 50)); y = 32'($urandom_range(1, 9)); end
                3: begin x = -32'($urandom_range(0, 50)); y = $urandom; end
                default: begin x = $urandom; y = $urandom; end
            endcase
            run_op(o, x, y, 5'($urandom), got);
        end

        // Backpressure: hold out_ready low for 10 cycles with a competing request
        exp_r = model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        @(negedge clk);
        op = 3'd3; a = 32'h1234_5678; b = 32'h9ABC_DEF0; tag_in = 5'd21; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 200) begin @(negedge clk); k++; end
        in_valid = 1'b1; op = 3'd0; a = 32'd1; b = 32'd1; tag_in = 5'd30;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_result", result, exp_r);
            check("bp_tag", {27'b0, tag_out}, 32'd21);
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("bp_in_ready_after", {31'b0, in_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        check("bp_request_ignored", {31'b0, seen}, 32'd0);

        // Flush during CALC iteration 10
        @(negedge clk);
        op = 3'd0; a = $urandom; b = $urandom; tag_in = 5'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        check("flush_no_result", {31'b0, seen}, 32'd0);

        // Reset during CALC iteration 10
        @(negedge clk);
        op = 3'd5; a = $urandom; b = 32'd7; tag_in = 5'd17; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_tag", {27'b0, tag_out}, 32'd0);
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        check("reset_no_result", {31'b0, seen}, 32'd0);

        // Flush on the accept edge wins: nothing starts
        @(negedge clk);
        op = 3'd4; a = 32'd5; b = 32'd0; tag_in = 5'd4; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 begin in_valid = 1'b0; flush = 1'b0; end
        @(negedge clk);
        check("flush_accept_in_ready", {31'b0, in_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        check("flush_accept_no_result", {31'b0, seen}, 32'd0);

        run_op(3'd0, 32'd3, 32'd4, 5'd13, got);
        check("mul_3x4_after_abort", got, 32'd12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
